// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle: instruction-memory port, pipeline control inputs and IF/ID outputs.
// The FETCH_PERF_CNT_EN macro adds the fetch/stall performance counter outputs.
interface fetch_pc_unit_if;
  logic [31:0] pc_out;
  logic [31:0] inst_in;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  modport master (
    input  inst_in, stall, redirect_valid, redirect_target,
    output pc_out, if_inst, if_pc, if_valid, halted, fetch_count, stall_count
  );
  modport slave (
    output inst_in, stall, redirect_valid, redirect_target,
    input  pc_out, if_inst, if_pc, if_valid, halted, fetch_count, stall_count
  );
`else
  modport master (
    input  inst_in, stall, redirect_valid, redirect_target,
    output pc_out, if_inst, if_pc, if_valid, halted
  );
  modport slave (
    output inst_in, stall, redirect_valid, redirect_target,
    input  pc_out, if_inst, if_pc, if_valid, halted
  );
`endif
endinterface

// File: rtl/fetch_pc_unit.sv
// PC generation and IF/ID latch with stall, redirect flush and halt detection.
// Define FETCH_PERF_CNT_EN to add saturating fetch/stall counters.
module fetch_pc_unit #(
  parameter int unsigned ADDR_W      = 12,
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_unit_if.master bus
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

  localparam logic [ADDR_W-1:0] RESET_PC_W = RESET_PC[ADDR_W-1:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              if_valid_q, if_valid_d;
  logic              halted_q, halted_d;
  logic              fetch_c;
  logic              stall_cnt_c;
  logic              unused_target_bits;

  assign unused_target_bits = ^bus.redirect_target[31:ADDR_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC_W;
      if_inst_q  <= 32'd0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
    end
  end

  // Redirect outranks stall and halt detection; BOOT ignores everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_inst_d   = if_inst_q;
    if_pc_d     = if_pc_q;
    if_valid_d  = if_valid_q;
    fetch_c     = 1'b0;
    stall_cnt_c = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        state_d    = ST_RUN;
        if_valid_d = 1'b0;
      end
      ST_RUN: begin
        if (bus.redirect_valid) begin
          pc_d       = bus.redirect_target[ADDR_W-1:0];
          if_valid_d = 1'b0;
        end else if (bus.stall) begin
          stall_cnt_c = 1'b1;
        end else begin
          if_inst_d  = bus.inst_in;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          fetch_c    = 1'b1;
          if (bus.inst_in[31:26] == HALT_OPCODE) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      ST_HALT: begin
        if_valid_d = 1'b0;
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_target[ADDR_W-1:0];
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  assign bus.pc_out   = 32'(pc_q);
  assign bus.if_inst  = if_inst_q;
  assign bus.if_pc    = 32'(if_pc_q);
  assign bus.if_valid = if_valid_q;
  assign bus.halted   = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Saturating event counters.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (fetch_c && (fetch_count_q != 32'hFFFF_FFFF)) fetch_count_d = fetch_count_q + 32'd1;
    if (stall_cnt_c && (stall_count_q != 32'hFFFF_FFFF)) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.fetch_count = fetch_count_q;
  assign bus.stall_count = stall_count_q;
`else
  logic unused_perf_events;
  assign unused_perf_events = fetch_c ^ stall_cnt_c;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table-driven bench for fetch_pc_unit with a behavioural instruction memory.
module tb_fetch_pc_unit;

  logic clk;
  logic rst_n;
  logic [31:0] mem [0:4095];
  int n_cmp;
  int n_fail;

  fetch_pc_unit_if bus();

  fetch_pc_unit dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.inst_in = rst_n ? mem[bus.pc_out[11:0]] : 32'h0;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_ifpc;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " pc_out"},   bus.pc_out,           v.e_pc);
    chk({tag, " if_inst"},  bus.if_inst,          v.e_inst);
    chk({tag, " if_pc"},    bus.if_pc,            v.e_ifpc);
    chk({tag, " if_valid"}, 32'(bus.if_valid),    32'(v.e_valid));
    chk({tag, " halted"},   32'(bus.halted),      32'(v.e_halted));
  endtask

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] tgt,
                              input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] ifpc, input logic v, input logic h);
    vec_t r;
    r.stall = st; r.rv = rv; r.tgt = tgt; r.e_pc = pc; r.e_inst = inst;
    r.e_ifpc = ifpc; r.e_valid = v; r.e_halted = h;
    return r;
  endfunction

  initial begin
    vec_t rv0;
    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[0]    = 32'h0020000F;
    mem[1]    = 32'h0421000F;
    mem[2]    = 32'h08400004;
    mem[3]    = 32'h0C000003;
    mem[4]    = 32'hFC000000;
    mem[5]    = 32'h14000005;
    mem[20]   = 32'h50000014;
    mem[4095] = 32'hAAAA5555;

    vt[0]  = mk(0, 0, 32'h0,    32'd0,   32'h0,        32'd0,   0, 0);
    vt[1]  = mk(0, 0, 32'h0,    32'd1,   32'h0020000F, 32'd0,   1, 0);
    vt[2]  = mk(0, 0, 32'h0,    32'd2,   32'h0421000F, 32'd1,   1, 0);
    vt[3]  = mk(0, 0, 32'h0,    32'd3,   32'h08400004, 32'd2,   1, 0);
    vt[4]  = mk(1, 0, 32'h0,    32'd3,   32'h08400004, 32'd2,   1, 0);
    vt[5]  = mk(1, 0, 32'h0,    32'd3,   32'h08400004, 32'd2,   1, 0);
    vt[6]  = mk(1, 0, 32'h0,    32'd3,   32'h08400004, 32'd2,   1, 0);
    vt[7]  = mk(0, 0, 32'h0,    32'd4,   32'h0C000003, 32'd3,   1, 0);
    vt[8]  = mk(1, 1, 32'h1005, 32'd5,   32'h0C000003, 32'd3,   0, 0);
    vt[9]  = mk(0, 0, 32'h0,    32'd6,   32'h14000005, 32'd5,   1, 0);
    vt[10] = mk(0, 1, 32'h4,    32'd4,   32'h14000005, 32'd5,   0, 0);
    vt[11] = mk(0, 0, 32'h0,    32'd4,   32'hFC000000, 32'd4,   1, 1);
    vt[12] = mk(0, 0, 32'h0,    32'd4,   32'hFC000000, 32'd4,   0, 1);
    vt[13] = mk(1, 0, 32'h0,    32'd4,   32'hFC000000, 32'd4,   0, 1);
    vt[14] = mk(0, 1, 32'h0,    32'd0,   32'hFC000000, 32'd4,   0, 0);
    vt[15] = mk(0, 0, 32'h0,    32'd1,   32'h0020000F, 32'd0,   1, 0);
    vt[16] = mk(0, 1, 32'hFFF,  32'd4095, 32'h0020000F, 32'd0,  0, 0);
    vt[17] = mk(0, 0, 32'h0,    32'd0,   32'hAAAA5555, 32'd4095, 1, 0);
    vt[18] = mk(0, 1, 32'd10,   32'd10,  32'hAAAA5555, 32'd4095, 0, 0);
    vt[19] = mk(1, 1, 32'd20,   32'd20,  32'hAAAA5555, 32'd4095, 0, 0);
    vt[20] = mk(0, 0, 32'h0,    32'd21,  32'h50000014, 32'd20,  1, 0);
    vt[21] = mk(0, 1, 32'h4,    32'd4,   32'h50000014, 32'd20,  0, 0);
    vt[22] = mk(0, 1, 32'h6,    32'd6,   32'h50000014, 32'd20,  0, 0);
    vt[23] = mk(0, 0, 32'h0,    32'd7,   32'h00000000, 32'd6,   1, 0);

    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    rst_n = 1'b0;
    #12;
    rv0 = mk(0, 0, 32'h0, 32'd0, 32'h0, 32'd0, 0, 0);
    chk_all("reset", rv0);
`ifdef FETCH_PERF_CNT_EN
    chk("reset fetch_count", bus.fetch_count, 32'd0);
    chk("reset stall_count", bus.stall_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      bus.stall = vt[i].stall;
      bus.redirect_valid = vt[i].rv;
      bus.redirect_target = vt[i].tgt;
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vt[i]);
`ifdef FETCH_PERF_CNT_EN
      if (i == 6) begin
        chk("fetch_count after stall", bus.fetch_count, 32'd3);
        chk("stall_count after stall", bus.stall_count, 32'd3);
      end
      if (i == NV - 1) begin
        chk("fetch_count end", bus.fetch_count, 32'd10);
        chk("stall_count end", bus.stall_count, 32'd3);
      end
`endif
    end
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async reset", rv0);
`ifdef FETCH_PERF_CNT_EN
    chk("async reset fetch_count", bus.fetch_count, 32'd0);
    chk("async reset stall_count", bus.stall_count, 32'd0);
`endif

    // Redirect during BOOT is ignored.
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd7;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all("boot redirect ignored", rv0);
    bus.redirect_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all("first fetch after boot", mk(0, 0, 32'h0, 32'd1, 32'h0020000F, 32'd0, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Program-counter and fetch-latch stage directly upstream of instruction_memory. It drives the word-addressed PC into the combinational instruction memory and captures the returned instruction together with its PC into an IF/ID register. It also handles stall, redirect (branch/jump) flushing and halt detection. The decode stage consumes the IF/ID outputs.

Parameters:
ADDR_W, 12, PC width actually used (word index); pc_out upper bits [31:ADDR_W] always 0
RESET_PC, 0, PC value loaded on reset (masked to ADDR_W bits)
HALT_OPCODE, 6'b111111, inst[31:26] value treated as halt

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
pc_out  output  32  word address to instruction_memory pc input
inst_in  input  32  instruction returned combinationally for pc_out (same cycle)
stall  input  1  hold PC and IF/ID register
redirect_valid  input  1  load redirect_target as next PC, flush IF/ID
redirect_target  input  32  new PC; bits [31:ADDR_W] ignored
if_inst  output  32  latched instruction to decode
if_pc  output  32  PC of if_inst
if_valid  output  1  if_inst/if_pc hold a live instruction
halted  output  1  unit in HALT state

Behaviour:
- Reset (rst=0, async): pc_out=RESET_PC, if_inst=0, if_pc=0, if_valid=0, halted=0, state=BOOT.
- States: BOOT, RUN, HALT.
- BOOT: lasts exactly one cycle after rst deasserts. PC holds, if_valid=0. Always transitions to RUN. Covers the instruction_memory output being forced to 0 during reset.
- RUN, no stall/redirect: each edge latches if_inst<=inst_in, if_pc<=pc_out, if_valid<=1, pc<=pc+1. Latency is 1 cycle from pc_out to if_inst.
- PC arithmetic: increment is modulo 2^ADDR_W. PC 4095 rolls over to 0 with no flag.
- stall=1 (RUN, no redirect): PC, if_inst, if_pc and if_valid all hold.
- redirect_valid=1 (any state except BOOT): pc<=redirect_target masked to ADDR_W bits, if_valid<=0 (flush), if_inst/if_pc hold their old values. Redirect has priority over stall and over halt detection in the same cycle.
- Redirect in BOOT: ignored.
- Halt: in RUN, with no stall and no redirect, an edge capturing inst_in[31:26]==HALT_OPCODE does the following:
  - latches that instruction normally (if_valid=1 for one cycle);
  - moves to HALT; pc does not increment.
- HALT: halted=1, pc frozen, if_valid<=0 from the next edge on, stall ignored. Exit only by redirect_valid (go to RUN at the target, halted<=0 on the same edge) or by reset.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.
- Back-to-back redirects: each one wins; the last target is fetched and if_valid stays 0 until one non-redirect, non-stall RUN edge occurs.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on every edge where if_valid is written to 1.
  - stall_count increments on every RUN edge with stall=1 and redirect_valid=0.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset release, then memory contents 0020000F,0421000F,08400004 at words 0-2 -> BOOT: 1 cycle with if_valid=0. Then if_inst=0020000F/if_pc=0, 0421000F/1, 08400004/2 on consecutive cycles.
- stall=1 for 3 cycles while pc_out=3 -> pc_out stays 3, if_inst/if_pc/if_valid unchanged. Fetch resumes with inst at word 3 one cycle after stall drops.
- redirect_valid=1, target=0x0000_1005, with stall=1 on the same cycle -> next pc_out=0x005 (upper bits masked), if_valid=0. The following cycle gives if_pc=5.
- Word 4 = FC000000 (opcode 111111) -> if_inst=FC000000 with if_valid=1 for one cycle, then halted=1, if_valid=0, pc_out frozen at 4. Redirect to 0 -> halted=0 and fetch restarts at 0.
- redirect to 4095, run 2 cycles -> if_pc=4095, then pc_out=0 (wrap).
- Assert rst=0 mid-run between clock edges -> outputs return to reset values immediately. With FETCH_PERF_CNT_EN, fetch_count=3 and stall_count=3 after the stimulus of scenarios 1-2, and both are 0 after reset.
